// File: rtl/cpu_isa_pkg.sv
// rtl/cpu_isa_pkg.sv - instruction field layout and loader state encoding shared by the CPU program loader
package cpu_isa_pkg;

    localparam int INSTR_W     = 16;
    localparam int ALU_SEL_BIT = 12;
    localparam int DST_MSB     = 10;
    localparam int DST_LSB     = 8;
    localparam int SRC1_MSB    = 6;
    localparam int SRC1_LSB    = 4;
    localparam int SRC2_MSB    = 2;
    localparam int SRC2_LSB    = 0;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_LOAD  = 2'd1,
        ST_WRITE = 2'd2,
        ST_START = 2'd3
    } loader_state_t;

endpackage

// File: rtl/cpu_program_loader_if.sv
// rtl/cpu_program_loader_if.sv - instruction field stream in, instruction RAM write port out
interface cpu_program_loader_if #(
    parameter int DATA_W = 32
);
    logic              in_valid;
    logic              in_ready;
    logic              in_last;
    logic              in_alu_sel;
    logic [2:0]        in_dst;
    logic [2:0]        in_src1;
    logic [2:0]        in_src2;
    logic [2:0]        mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mem_we;

    // Host side: supplies instruction fields and observes the RAM writes.
    modport master (
        output in_valid, in_last, in_alu_sel, in_dst, in_src1, in_src2,
        input  in_ready, mem_addr, mem_wdata, mem_we
    );

    // Loader side.
    modport slave (
        input  in_valid, in_last, in_alu_sel, in_dst, in_src1, in_src2,
        output in_ready, mem_addr, mem_wdata, mem_we
    );
endinterface

// File: rtl/cpu_instr_encoder.sv
// rtl/cpu_instr_encoder.sv - packs decoded fields into a 16-bit instruction word; CPU_LOADER_PARITY_EN sets bit 15 to even parity
module cpu_instr_encoder
    import cpu_isa_pkg::*;
(
    input  logic               alu_sel,
    input  logic [2:0]         dst,
    input  logic [2:0]         src1,
    input  logic [2:0]         src2,
    output logic [INSTR_W-1:0] instr
);

    logic [INSTR_W-2:0] body;

    always_comb begin
        body                    = '0;
        body[ALU_SEL_BIT]       = alu_sel;
        body[DST_MSB:DST_LSB]   = dst;
        body[SRC1_MSB:SRC1_LSB] = src1;
        body[SRC2_MSB:SRC2_LSB] = src2;
    end

`ifdef CPU_LOADER_PARITY_EN
    // Top bit makes the total number of ones in the word even.
    assign instr = {^body, body};
`else
    assign instr = {1'b0, body};
`endif

endmodule

// File: rtl/cpu_program_loader.sv
// rtl/cpu_program_loader.sv - streams encoded instructions into the 8-entry instruction RAM and pulses start when done
module cpu_program_loader
    import cpu_isa_pkg::*;
#(
    parameter int DEPTH  = 8,
    parameter int DATA_W = 32
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 load_go,
    cpu_program_loader_if.slave  bus,
    output logic                 start,
    output logic [3:0]           count,
    output logic                 busy
);

    loader_state_t      state;
    logic [2:0]         addr;
    logic               last_q;
    logic [INSTR_W-1:0] instr;

    cpu_instr_encoder u_encoder (
        .alu_sel (bus.in_alu_sel),
        .dst     (bus.in_dst),
        .src1    (bus.in_src1),
        .src2    (bus.in_src2),
        .instr   (instr)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state         <= ST_IDLE;
            addr          <= '0;
            last_q        <= 1'b0;
            count         <= '0;
            start         <= 1'b0;
            busy          <= 1'b0;
            bus.in_ready  <= 1'b0;
            bus.mem_we    <= 1'b0;
            bus.mem_addr  <= '0;
            bus.mem_wdata <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (load_go) begin
                        addr         <= '0;
                        count        <= '0;
                        busy         <= 1'b1;
                        bus.in_ready <= 1'b1;
                        state        <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (bus.in_valid) begin
                        bus.mem_addr  <= addr;
                        bus.mem_wdata <= {{(DATA_W-INSTR_W){1'b0}}, instr};
                        bus.mem_we    <= 1'b1;
                        bus.in_ready  <= 1'b0;
                        last_q        <= bus.in_last;
                        state         <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    bus.mem_we <= 1'b0;
                    addr       <= addr + 3'd1;
                    count      <= count + 4'd1;
                    // A full RAM ends the program even without a last flag.
                    if (last_q || (count == 4'(DEPTH - 1))) begin
                        start <= 1'b1;
                        state <= ST_START;
                    end else begin
                        bus.in_ready <= 1'b1;
                        state        <= ST_LOAD;
                    end
                end
                ST_START: begin
                    start <= 1'b0;
                    busy  <= 1'b0;
                    state <= ST_IDLE;
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: doc/cpu_program_loader.md
# cpu_program_loader

Sequential writer that builds the CPU's 16-bit instruction words from decoded fields and streams them into the 8-entry instruction RAM (ram8). It encodes the fields the CPU decoder reads back: bit 12 ALU select, [10:8] destination, [6:4] source 1 and [2:0] source 2. It sits between a host or testbench source and the ram8 write port. When loading finishes, it pulses a start strobe so the CPU can reset its PC and begin fetching.

## Interface
Parameters:
- DEPTH, 8, number of RAM entries; fixed to 8 because the address is 3 bits.
- DATA_W, 32, RAM word width; the encoded instruction is zero-extended into it.

Ports:
- clk  input  1  single clock; all state changes on the rising edge.
- reset  input  1  asynchronous, active-high reset.
- load_go  input  1  one-cycle request to begin a new program; honoured only in IDLE.
- in_valid  input  1  instruction fields on the in_* inputs are valid.
- in_ready  output  1  loader can accept the fields this cycle.
- in_last  input  1  marks the final instruction of the program.
- in_alu_sel  input  1  ALU operation select.
- in_dst  input  3  destination RAM address.
- in_src1  input  3  first operand RAM address.
- in_src2  input  3  second operand RAM address.
- mem_addr  output  3  RAM write address.
- mem_wdata  output  32  RAM write data.
- mem_we  output  1  RAM write enable, high for exactly one cycle per word.
- start  output  1  one-cycle pulse after the last word is written.
- count  output  4  number of words written in the current program (0..8).
- busy  output  1  high in every state except IDLE.

## Operation
- Instruction encoding (16 bits):
  - [12]=alu_sel, [10:8]=dst, [6:4]=src1, [2:0]=src2.
  - Bits 15, 14, 13, 11, 7 and 3 are 0 (bit 15 changes only under Configuration).
  - mem_wdata = {16'h0, instr}.
- States: IDLE, LOAD, WRITE, START.
- IDLE: in_ready=0. On load_go: clear the address counter and count, then go to LOAD.
- LOAD: in_ready=1. On in_valid && in_ready:
  - register the encoded word and the current address;
  - latch in_last;
  - go to WRITE.
- WRITE: mem_we=1 with the registered address and data; in_ready=0; the address counter and count increment.
  - Go to START if the latched last flag is set, or if count reaches 8.
  - Otherwise return to LOAD.
- START: start=1 for one cycle, then go to IDLE.
- Full boundary: after 8 words without in_last, the loader forces START. The address counter wraps to 0 but is never used again before the next load_go.
- load_go outside IDLE is ignored. in_valid outside LOAD is ignored; no fields are captured.
- count holds its final value in IDLE until the next load_go.

## Timing
- Reset values: in_ready=0, mem_we=0, mem_addr=0, mem_wdata=0, start=0, count=0, busy=0; state=IDLE.
- Reset asserted mid-program: everything returns to reset values immediately (asynchronously). A partially loaded program is abandoned and no start is issued.
- load_go in cycle N: LOAD and in_ready=1 from cycle N+1.
- Handshake accepted in cycle N: mem_we=1 in cycle N+1; in_ready=1 again in cycle N+2.
- Throughput is one word per 2 cycles.
- The last word's mem_we is in cycle M; start=1 in cycle M+1; busy=0 from cycle M+2.
- Program of k words: load_go to start pulse takes 2k+1 cycles.

## Configuration
- CPU_LOADER_PARITY_EN defined: instr[15] = XOR of instr[14:0], giving even parity across the 16-bit word.
- CPU_LOADER_PARITY_EN undefined: instr[15]=0. All timing is identical in both builds.

## Structure
- Shared package cpu_isa_pkg holds:
  - the field position constants ALU_SEL_BIT=12, DST_MSB/LSB=10/8, SRC1_MSB/LSB=6/4, SRC2_MSB/LSB=2/0;
  - the instruction width (16);
  - the loader state enum.
- Sub-module cpu_instr_encoder: combinational field-to-word packing, including the parity option. Reusable by the bench's reference model.
- The top level holds the FSM, the address counter and the output registers.

## Test plan
- Single instruction: load_go, then fields alu_sel=1, dst=5, src1=3, src2=6, last=1 -> mem_we one cycle, mem_addr=0, mem_wdata=0x00001536, start on the next cycle, count=1.
- Parity build of the same word -> mem_wdata=0x00009536. Fields all zero -> 0x00000000.
- Three words with in_valid gaps of 0, 2 and 5 cycles -> addresses 0, 1, 2 written in order, each mem_we exactly one cycle, start once after address 2, count=3.
- Eight words, none flagged last -> writes to addresses 0..7, then start is forced, count=8; a ninth in_valid is not accepted (in_ready=0).
- Reset asserted in the cycle mem_we=1 for address 2 -> all outputs return to 0 at once, no start pulse, next load_go restarts at address 0.
- load_go pulsed during LOAD, and in_valid held high in IDLE -> no state change, no writes.
